// File: rtl/channel_code_synthesizer_pkg.sv
// Shared parameters for the channel code synthesizer slice.
//
// constant_gpack    : lane count and ADC code width, common to the receive
//                     datapath so loopback lane layouts line up.
// chan_synth_gpack  : channel model parameters (tap count, tap width, shift
//                     width), the derived history depth and accumulator width,
//                     plus the tap/code element types used on the ports.

package constant_gpack;
    localparam int channel_width  = 16;
    localparam int code_precision = 8;
endpackage

package chan_synth_gpack;
    import constant_gpack::*;

    localparam int chan_length     = 8;
    localparam int tap_precision   = 8;
    localparam int shift_precision = 4;

    // Number of past frames the impulse response can reach back into.
    localparam int hist_depth = (chan_length - 1 + channel_width - 1) / channel_width;

    // Sum of chan_length terms of +/-tap: one growth bit per doubling of the
    // term count plus one for negating the most negative tap value.
    localparam int acc_width = tap_precision + $clog2(chan_length) + 1;

    typedef logic signed [tap_precision-1:0]  tap_t;
    typedef logic signed [code_precision-1:0] code_t;
endpackage

// File: rtl/chan_tap_mac.sv
// One lane of the channel code synthesizer: combinational multiply-accumulate
// of +/-1 symbols against the channel taps, followed by offset, arithmetic
// right shift and saturation to the ADC code range.
//
// Ports:
//   syms        : syms[k] is the symbol k UI before this lane (1 -> +1, 0 -> -1)
//   taps        : active channel impulse response, taps[k] weights syms[k]
//   code_offset : signed offset added to the accumulator before shifting
//   code_shift  : arithmetic right shift amount
//   code        : saturated signed output code

module chan_tap_mac
    import constant_gpack::*;
    import chan_synth_gpack::*;
(
    input  logic [chan_length-1:0]     syms,
    input  tap_t                       taps [chan_length],
    input  code_t                      code_offset,
    input  logic [shift_precision-1:0] code_shift,
    output code_t                      code
);

    // One extra bit over the wider operand so the offset add cannot wrap.
    localparam int SUM_W = ((acc_width > code_precision) ? acc_width : code_precision) + 1;
    localparam logic signed [SUM_W-1:0] CODE_MAX = SUM_W'((1 << (code_precision - 1)) - 1);
    localparam logic signed [SUM_W-1:0] CODE_MIN = ~CODE_MAX;

    logic signed [acc_width-1:0] acc;
    logic signed [acc_width-1:0] tap_ext;
    logic signed [SUM_W-1:0]     acc_ext;
    logic signed [SUM_W-1:0]     off_ext;
    logic signed [SUM_W-1:0]     biased;
    logic signed [SUM_W-1:0]     shifted;

    // Products are just +tap or -tap, so the MAC reduces to add/subtract.
    always_comb begin
        acc     = '0;
        tap_ext = '0;
        for (int k = 0; k < chan_length; k++) begin
            tap_ext = {{(acc_width - tap_precision){taps[k][tap_precision-1]}}, taps[k]};
            if (syms[k]) begin
                acc = acc + tap_ext;
            end else begin
                acc = acc - tap_ext;
            end
        end
    end

    assign acc_ext = {{(SUM_W - acc_width){acc[acc_width-1]}}, acc};
    assign off_ext = {{(SUM_W - code_precision){code_offset[code_precision-1]}}, code_offset};
    assign biased  = acc_ext + off_ext;
    // Signed operand: >>> rounds toward minus infinity.
    assign shifted = biased >>> code_shift;

    always_comb begin
        code = shifted[code_precision-1:0];
        if (shifted > CODE_MAX) begin
            code = CODE_MAX[code_precision-1:0];
        end else if (shifted < CODE_MIN) begin
            code = CODE_MIN[code_precision-1:0];
        end
    end

endmodule

// File: rtl/signed_buffer.sv
// Multi-lane signed register pipeline with a per-stage load enable.
// A stage only captures when its load bit is set, so a stage holds its last
// value across gaps in the data stream.
//
// Ports:
//   clk, rstb : clock and synchronous active-low reset (clears every stage)
//   load      : load[s] enables capture into stage s (stage 0 takes data_in)
//   data_in   : lane values entering stage 0
//   data_out  : lane values of the final stage

module signed_buffer #(
    parameter int lanes  = 16,
    parameter int width  = 8,
    parameter int stages = 1
) (
    input  logic                    clk,
    input  logic                    rstb,
    input  logic [stages-1:0]       load,
    input  logic signed [width-1:0] data_in  [lanes],
    output logic signed [width-1:0] data_out [lanes]
);

    logic signed [width-1:0] pipe_reg [stages][lanes];

    always_ff @(posedge clk) begin
        if (!rstb) begin
            for (int s = 0; s < stages; s++) begin
                for (int l = 0; l < lanes; l++) begin
                    pipe_reg[s][l] <= '0;
                end
            end
        end else begin
            if (load[0]) begin
                for (int l = 0; l < lanes; l++) begin
                    pipe_reg[0][l] <= data_in[l];
                end
            end
            for (int s = 1; s < stages; s++) begin
                if (load[s]) begin
                    for (int l = 0; l < lanes; l++) begin
                        pipe_reg[s][l] <= pipe_reg[s-1][l];
                    end
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < lanes; gi++) begin : g_out
            assign data_out[gi] = pipe_reg[stages-1][gi];
        end
    endgenerate

endmodule

// File: rtl/channel_code_synthesizer.sv
// Transmit-side channel emulator: turns frames of transmitted bits into
// synthetic signed ADC codes by convolving +/-1 symbols with a programmable
// channel impulse response, then offsetting, shifting and saturating. The
// output lane layout matches the receive datapath's ADC code input.
//
// Ports:
//   clk, rstb       : clock and synchronous active-low reset
//   bits_in         : frame of bits, lane 0 oldest; 1 -> +1, 0 -> -1
//   bits_in_valid   : frame present this cycle
//   taps_in         : new tap set, taps_in[k] weights the symbol k UI earlier
//   taps_load       : capture taps_in into the active tap set
//   code_offset     : offset added before the shift (sampled with the frame)
//   code_shift      : arithmetic right shift (sampled with the frame)
//   codes_out       : synthesized codes, one per lane
//   codes_out_valid : codes_out carries a new frame this cycle
//   primed          : enough frames seen to fill the history
//
// Latency: a frame accepted at edge N is presented after edge
// N + 1 + pipeline_depth.

module channel_code_synthesizer
    import constant_gpack::*;
    import chan_synth_gpack::*;
#(
    parameter int pipeline_depth = 1
) (
    input  logic                       clk,
    input  logic                       rstb,
    input  logic [channel_width-1:0]   bits_in,
    input  logic                       bits_in_valid,
    input  tap_t                       taps_in [chan_length],
    input  logic                       taps_load,
    input  code_t                      code_offset,
    input  logic [shift_precision-1:0] code_shift,
    output code_t                      codes_out [channel_width],
    output logic                       codes_out_valid,
    output logic                       primed
);

    // Symbol window seen by the MACs: the chan_length-1 most recent past
    // symbols (oldest at bit 0) followed by the current frame.
    localparam int WIN_LEN = channel_width + chan_length - 1;
    localparam int CNT_W   = $clog2(hist_depth + 2);
    // Result register plus pipeline_depth extra stages plus the output stage.
    localparam int STAGES  = pipeline_depth + 2;

    tap_t                taps_reg [chan_length];
    logic [WIN_LEN-1:0]  window;
    logic [CNT_W-1:0]    prime_cnt_reg;
    logic                accept_frame;
    logic [STAGES-1:0]   valid_reg;
    code_t               lane_code [channel_width];

    // ------------------------------------------------------------------
    // Active tap set. A frame accepted on the same edge as a load still sees
    // the old taps because the MACs read taps_reg before it updates.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstb) begin
            for (int k = 0; k < chan_length; k++) begin
                taps_reg[k] <= '0;
            end
        end else if (taps_load) begin
            for (int k = 0; k < chan_length; k++) begin
                taps_reg[k] <= taps_in[k];
            end
        end
    end

    // ------------------------------------------------------------------
    // Symbol history. Only the last chan_length-1 symbols can reach a tap,
    // so that is all that is stored; it spans hist_depth past frames.
    // ------------------------------------------------------------------
    generate
        if (chan_length > 1) begin : g_hist
            logic [chan_length-2:0] history_reg;

            always_ff @(posedge clk) begin
                if (!rstb) begin
                    history_reg <= '0;
                end else if (bits_in_valid) begin
                    history_reg <= window[WIN_LEN-1 -: (chan_length - 1)];
                end
            end

            assign window = {bits_in, history_reg};
        end else begin : g_no_hist
            assign window = bits_in;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Priming: count valid frames up to hist_depth. Outputs are produced only
    // for frames arriving once the history holds real data.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstb) begin
            prime_cnt_reg <= '0;
        end else if (bits_in_valid && !primed) begin
            prime_cnt_reg <= prime_cnt_reg + CNT_W'(1);
        end
    end

    assign primed       = (prime_cnt_reg == CNT_W'(hist_depth));
    assign accept_frame = bits_in_valid && primed;

    // ------------------------------------------------------------------
    // Per-lane MACs. Lane gi sits at window position chan_length-1+gi, so
    // the symbol k UI earlier is k positions below it.
    // ------------------------------------------------------------------
    genvar gi, gk;
    generate
        for (gi = 0; gi < channel_width; gi++) begin : g_lane
            logic [chan_length-1:0] lane_syms;

            for (gk = 0; gk < chan_length; gk++) begin : g_sym
                assign lane_syms[gk] = window[chan_length - 1 + gi - gk];
            end

            chan_tap_mac u_mac (
                .syms        (lane_syms),
                .taps        (taps_reg),
                .code_offset (code_offset),
                .code_shift  (code_shift),
                .code        (lane_code[gi])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Valid shift register. valid_reg[s] marks that code stage s holds a new
    // frame, which is also the load enable for stage s+1.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstb) begin
            valid_reg <= '0;
        end else begin
            valid_reg <= {valid_reg[STAGES-2:0], accept_frame};
        end
    end

    assign codes_out_valid = valid_reg[STAGES-1];

    signed_buffer #(
        .lanes  (channel_width),
        .width  (code_precision),
        .stages (STAGES)
    ) u_code_pipe (
        .clk      (clk),
        .rstb     (rstb),
        .load     ({valid_reg[STAGES-2:0], accept_frame}),
        .data_in  (lane_code),
        .data_out (codes_out)
    );

endmodule
